// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV64 instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    ERROR = 2'd3
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_0000_0000;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
    return (addr_lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: JALR over taken branch over sequential, with alignment check.
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] branch_imm,
  input  logic [XLEN-1:0] jalr_base,
  input  logic            branch_taken,
  input  logic            jalr_en,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  // Target select; all sums wrap modulo 2^XLEN.
  always_comb begin
    next_pc = pc + XLEN'(INSTR_BYTES);
    if (jalr_en) begin
      next_pc = (jalr_base + branch_imm) & ~XLEN'(1);
    end else if (branch_taken) begin
      next_pc = pc + branch_imm;
    end else begin
      next_pc = pc + XLEN'(INSTR_BYTES);
    end
  end

  assign misaligned = !is_word_aligned(next_pc[1:0]);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential fetch stage: PC register, memory request handshake and
// valid/ready hand-off of each instruction to decode.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  input  logic            branch_taken,
  input  logic            jalr_en,
  input  logic [XLEN-1:0] jalr_base,
  input  logic [XLEN-1:0] branch_imm,
  output logic            misalign_err
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] next_pc_s;
  logic            misaligned_s;

  next_pc_calc #(.XLEN(XLEN)) u_next_pc_calc (
    .pc           (pc_q),
    .branch_imm   (branch_imm),
    .jalr_base    (jalr_base),
    .branch_taken (branch_taken),
    .jalr_en      (jalr_en),
    .next_pc      (next_pc_s),
    .misaligned   (misaligned_s)
  );

  // Next-state logic; req/valid are computed for the upcoming state so they leave as flops.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    req_d   = 1'b0;
    valid_d = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = VALID;
          valid_d = 1'b1;
        end else begin
          req_d = 1'b1;
        end
      end
      VALID: begin
        if (instr_ready) begin
          pc_d = next_pc_s;
          if (misaligned_s) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = FETCH;
            req_d   = 1'b1;
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      ERROR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign instr        = instr_q;
  assign instr_valid  = valid_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed table-driven bench for instruction_fetch_unit plus reset corner sequences.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        branch_taken = 1'b0;
  logic        jalr_en = 1'b0;
  logic [63:0] jalr_base = 64'h0;
  logic [63:0] branch_imm = 64'h0;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  instruction_fetch_unit #(.XLEN(64), .RESET_PC(64'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .pc           (pc),
    .branch_taken (branch_taken),
    .jalr_en      (jalr_en),
    .jalr_base    (jalr_base),
    .branch_imm   (branch_imm),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [31:0] rdata;
    logic        irdy;
    logic        bt;
    logic        je;
    logic [63:0] base;
    logic [63:0] imm;
    logic        ereq;
    logic [63:0] eaddr;
    logic        evalid;
    logic [31:0] einstr;
    logic        eerr;
  } vec_t;

  localparam int NV = 34;
  vec_t vt[NV];

  function automatic vec_t mk(logic rdy, logic [31:0] rdata, logic irdy, logic bt, logic je,
                              logic [63:0] base, logic [63:0] imm, logic ereq,
                              logic [63:0] eaddr, logic evalid, logic [31:0] einstr,
                              logic eerr);
    vec_t v;
    v.rdy = rdy; v.rdata = rdata; v.irdy = irdy; v.bt = bt; v.je = je;
    v.base = base; v.imm = imm; v.ereq = ereq; v.eaddr = eaddr;
    v.evalid = evalid; v.einstr = einstr; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ereq, input logic [63:0] eaddr,
                         input logic evalid, input logic [31:0] einstr, input logic eerr);
    chk({tag, ".imem_req"}, {63'h0, imem_req}, {63'h0, ereq});
    chk({tag, ".imem_addr"}, imem_addr, eaddr);
    chk({tag, ".pc"}, pc, eaddr);
    chk({tag, ".instr_valid"}, {63'h0, instr_valid}, {63'h0, evalid});
    chk({tag, ".instr"}, {32'h0, instr}, {32'h0, einstr});
    chk({tag, ".misalign_err"}, {63'h0, misalign_err}, {63'h0, eerr});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // One vector per cycle: inputs driven for the cycle, outputs expected during it.
    vt[0]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    vt[1]  = mk(1'b1, 32'h00A00093, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h0, 1'b0, 32'h0, 1'b0);
    vt[2]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 1'b1, 32'h00A00093, 1'b0);
    for (int i = 3; i <= 5; i++)
      vt[i] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h4, 1'b0, 32'h00A00093, 1'b0);
    vt[6]  = mk(1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h4, 1'b0, 32'h00A00093, 1'b0);
    // Backpressure with stray memory data and branch inputs that must be ignored.
    for (int i = 7; i <= 11; i++)
      vt[i] = mk(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 64'h0, 64'h40, 1'b0, 64'h4, 1'b1, 32'h00000013, 1'b0);
    vt[12] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h4, 1'b1, 32'h00000013, 1'b0);
    vt[13] = mk(1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h8, 1'b0, 32'h00000013, 1'b0);
    vt[14] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 64'h0, 64'h8, 1'b0, 64'h8, 1'b1, 32'h11111111, 1'b0);
    vt[15] = mk(1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h10, 1'b0, 32'h11111111, 1'b0);
    vt[16] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 64'h10, 1'b1, 32'h22222222, 1'b0);
    vt[17] = mk(1'b1, 32'h33333333, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h8, 1'b0, 32'h22222222, 1'b0);
    vt[18] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 64'h0, 64'h8, 1'b0, 64'h8, 1'b1, 32'h33333333, 1'b0);
    vt[19] = mk(1'b1, 32'h44444444, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h10, 1'b0, 32'h33333333, 1'b0);
    vt[20] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 64'h0, 64'h8, 1'b0, 64'h10, 1'b1, 32'h44444444, 1'b0);
    vt[21] = mk(1'b1, 32'h55555555, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h18, 1'b0, 32'h44444444, 1'b0);
    // JALR and branch together: JALR target 0x101 & ~1 = 0x100 wins.
    vt[22] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 64'h101, 64'h0, 1'b0, 64'h18, 1'b1, 32'h55555555, 1'b0);
    vt[23] = mk(1'b1, 32'h66666666, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h100, 1'b0, 32'h55555555, 1'b0);
    vt[24] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'hC, 1'b0, 64'h100, 1'b1, 32'h66666666, 1'b0);
    vt[25] = mk(1'b1, 32'h77777777, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'h66666666, 1'b0);
    vt[26] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 32'h77777777, 1'b0);
    vt[27] = mk(1'b1, 32'h88888888, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h0, 1'b0, 32'h77777777, 1'b0);
    vt[28] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 64'h0, 64'h10, 1'b0, 64'h0, 1'b1, 32'h88888888, 1'b0);
    vt[29] = mk(1'b1, 32'h99999999, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 64'h10, 1'b0, 32'h88888888, 1'b0);
    vt[30] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 64'h0, 64'h6, 1'b0, 64'h10, 1'b1, 32'h99999999, 1'b0);
    for (int i = 31; i <= 33; i++)
      vt[i] = mk(1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h16, 1'b0, 32'h99999999, 1'b1);

    // Reset state, then release so the first table cycle is IDLE.
    tick();
    tick();
    chk_all("reset", 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      imem_ready   = vt[i].rdy;
      imem_rdata   = vt[i].rdata;
      instr_ready  = vt[i].irdy;
      branch_taken = vt[i].bt;
      jalr_en      = vt[i].je;
      jalr_base    = vt[i].base;
      branch_imm   = vt[i].imm;
      chk_all($sformatf("vec%0d", i), vt[i].ereq, vt[i].eaddr, vt[i].evalid, vt[i].einstr,
              vt[i].eerr);
      tick();
    end

    // Reset out of ERROR, then assert reset asynchronously during a fetch wait.
    imem_ready = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0; jalr_en = 1'b0;
    rst = 1'b1;
    #1;
    chk_all("err_reset", 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    tick();
    rst = 1'b0;
    chk_all("idle2", 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    tick();
    chk_all("fetch_wait1", 1'b1, 64'h0, 1'b0, 32'h0, 1'b0);
    tick();
    chk_all("fetch_wait2", 1'b1, 64'h0, 1'b0, 32'h0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_reset", 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    imem_ready = 1'b1;
    imem_rdata = 32'hBADBADBA;
    tick();
    rst = 1'b0;
    chk_all("stale_idle", 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    imem_ready = 1'b0;
    tick();
    chk_all("restart_fetch", 1'b1, 64'h0, 1'b0, 32'h0, 1'b0);
    imem_ready = 1'b1;
    imem_rdata = 32'hCAFE0013;
    tick();
    chk_all("restart_valid", 1'b0, 64'h0, 1'b1, 32'hCAFE0013, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Sequential fetch stage for the RV64 single-cycle core. It holds the program counter, issues word requests to instruction memory, and presents each fetched 32-bit instruction with its PC to the decode/immediate-generation stage over a valid/ready handshake. It also takes the sign-extended immediate and branch/jump decisions back from that stage to compute the next PC.

## Interface
Parameters:
- RESET_PC, 64'h0, PC loaded on reset; must be 4-byte aligned.
- XLEN, 64, PC/immediate width.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction-memory request strobe.
- imem_addr  out  XLEN  request byte address, equal to `pc`.
- imem_ready  in  1  memory has returned data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- instr_valid  out  1  `instr` and `pc` hold a fetched instruction.
- instr_ready  in  1  downstream consumes the instruction this cycle.
- instr  out  32  fetched instruction.
- pc  out  XLEN  address of `instr`; holds the faulting target in ERROR.
- branch_taken  in  1  take PC-relative target.
- jalr_en  in  1  take register-relative target.
- jalr_base  in  XLEN  rs1 value for JALR.
- branch_imm  in  XLEN  sign-extended immediate from the immediate generator.
- misalign_err  out  1  sticky fetch-target misalignment flag.

## Operation
- FSM states: IDLE, FETCH, VALID, ERROR.
- IDLE: entered on reset; moves to FETCH unconditionally on the first clock edge after rst deasserts.
- FETCH: imem_req=1 and imem_addr=pc. If imem_ready=1, latch imem_rdata into `instr` and go to VALID. Otherwise stay in FETCH for any number of wait cycles.
- VALID: instr_valid=1, and `instr`/`pc` are stable. The handshake fires when instr_ready=1. On the handshake, compute the next PC with this priority:
  - if jalr_en: next = (jalr_base + branch_imm) & ~64'h1;
  - else if branch_taken: next = pc + branch_imm;
  - else: next = pc + 4.
- After the handshake: if next[1:0]==0, load pc=next and go to FETCH. Otherwise load pc=next, set misalign_err, and go to ERROR.
- branch_taken, jalr_en, jalr_base and branch_imm are sampled only in the handshake cycle and ignored otherwise.
- ERROR: imem_req=0, instr_valid=0, misalign_err=1. The block stays in ERROR until rst.
- Arithmetic: all additions are XLEN-bit and modulo 2^XLEN, so 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0. branch_imm is two's complement; negative offsets subtract.
- imem_ready outside FETCH is ignored.

## Timing
- Reset values: pc=RESET_PC, instr=32'h0, instr_valid=0, imem_req=0, misalign_err=0, state=IDLE.
- imem_addr follows pc combinationally.
- First imem_req is asserted in the 2nd cycle after rst release (IDLE lasts one cycle).
- With zero-wait memory and instr_ready held high, each instruction takes 2 cycles: FETCH then VALID. Each memory wait cycle adds 1.
- Data appears on `instr` the cycle after the imem_ready edge.
- Backpressure: while instr_valid=1 and instr_ready=0, `instr` and `pc` are held and no new request is issued.
- Reset asserted mid-fetch: returns to IDLE immediately (asynchronous). Any in-flight memory response is discarded, and no instr_valid is produced for it.
- Simultaneous branch_taken and jalr_en: jalr_en wins.

## Structure
- Shared package `fetch_pkg`:
  - state enum `fetch_state_t` {IDLE, FETCH, VALID, ERROR};
  - constant INSTR_BYTES=4;
  - constant DEFAULT_RESET_PC.
- Sub-module `next_pc_calc` (combinational): inputs pc, branch_imm, jalr_base, branch_taken, jalr_en; outputs next_pc and misaligned.
- Top level holds the FSM, the pc/instr registers and the memory handshake.

## Test plan
- Reset then run with zero-wait memory returning 32'h00A00093: pc=0 in FETCH, instr_valid with instr=32'h00A00093 at pc=0, next pc=4.
- Insert 3 wait cycles at pc=4: imem_req held for 4 cycles with imem_addr=4, instr_valid rises on the 5th.
- Hold instr_ready=0 for 5 cycles in VALID: instr and pc unchanged, imem_req=0; on release, FETCH at pc+4.
- Branch at pc=0x10 with branch_imm=8 → next FETCH at 0x18. Branch at pc=0x10 with branch_imm=-8 (64'hFFFF_FFFF_FFFF_FFF8) → next FETCH at 0x08.
- JALR with jalr_base=0x101, branch_imm=0 → FETCH at 0x100. Branch at pc=0x10 with imm=6 → ERROR, misalign_err=1, pc=0x16, no further requests until rst.
- Assert rst during a FETCH wait state, then return imem_ready after release: outputs return to reset values immediately, the stale response is ignored, and fetch restarts at RESET_PC.
